// File: rtl/unified_mem_arbiter.sv
// Arbiter for the shared RV32 instruction/data memory: one command at a time, data-first with fetch anti-starvation.
// Optional build macro ARB_PERF_CNT_EN adds the perf_if_stall / perf_d_grants counters.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              stall_if,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
`ifdef ARB_PERF_CNT_EN
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_d_grants
`else
  input  logic [31:0]       mem_rdata
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_r, state_s;
  logic [1:0] cnt_r, cnt_s;
  logic [3:0] starve_r, starve_s;
  logic       owner_d_r, owner_d_s;
  logic       owner_we_r, owner_we_s;
  logic       resp_s, issue_ok_s, pick_d_s, pick_i_s, resp_out_s;
  logic       unused_s;

  // Byte offset and high address bits never reach the word-addressed memory.
  assign unused_s = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

  // Arbitration, command drive, response routing and next-state logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    starve_s   = starve_r;
    owner_d_s  = owner_d_r;
    owner_we_s = owner_we_r;

    resp_s     = (state_r == BUSY) && (cnt_r == LAST_CNT);
    issue_ok_s = rst_n && ((state_r == IDLE) || resp_s);
    pick_d_s   = issue_ok_s && d_req && !(if_req && (starve_r == STARVE_LIM));
    pick_i_s   = issue_ok_s && if_req && !pick_d_s;
    resp_out_s = rst_n && resp_s;

    if_gnt    = pick_i_s;
    d_gnt     = pick_d_s;
    stall_if  = rst_n && if_req && !pick_i_s;
    mem_en    = pick_i_s || pick_d_s;
    mem_we    = pick_d_s && d_we;
    mem_wdata = pick_d_s ? d_wdata : 32'h0;
    if (pick_d_s) begin
      mem_be   = d_we ? d_be : 4'hF;
      mem_addr = d_addr[ADDR_W+1:2];
    end else if (pick_i_s) begin
      mem_be   = 4'hF;
      mem_addr = if_addr[ADDR_W+1:2];
    end else begin
      mem_be   = 4'h0;
      mem_addr = {ADDR_W{1'b0}};
    end

    if_rvalid = resp_out_s && !owner_d_r;
    d_rvalid  = resp_out_s && owner_d_r;
    if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    d_rdata   = (d_rvalid && !owner_we_r) ? mem_rdata : 32'h0;

    if (mem_en) begin
      state_s    = BUSY;
      cnt_s      = 2'd0;
      owner_d_s  = pick_d_s;
      owner_we_s = pick_d_s && d_we;
    end else if (resp_s) begin
      state_s = IDLE;
      cnt_s   = 2'd0;
    end else if (state_r == BUSY) begin
      cnt_s = cnt_r + 2'd1;
    end else begin
      cnt_s = 2'd0;
    end

    // Streak of data grants that fetch has sat through; saturates at the limit.
    if (!if_req || pick_i_s) begin
      starve_s = 4'd0;
    end else if (pick_d_s && (starve_r < STARVE_LIM)) begin
      starve_s = starve_r + 4'd1;
    end else begin
      starve_s = starve_r;
    end
  end

  // State, latency, starvation and owner registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 2'd0;
      starve_r   <= 4'd0;
      owner_d_r  <= 1'b0;
      owner_we_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      starve_r   <= starve_s;
      owner_d_r  <= owner_d_s;
      owner_we_r <= owner_we_s;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_stall_r, perf_dgnt_r;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_r <= 32'h0;
      perf_dgnt_r  <= 32'h0;
    end else begin
      perf_stall_r <= perf_stall_r + {31'h0, stall_if};
      perf_dgnt_r  <= perf_dgnt_r + {31'h0, d_gnt};
    end
  end

  assign perf_if_stall = rst_n ? perf_stall_r : 32'h0;
  assign perf_d_grants = rst_n ? perf_dgnt_r : 32'h0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: three instances with MEM_LAT 1, 2 and 3, one exercised at a time.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        if_req [3];
  logic [31:0] if_addr [3];
  logic        if_gnt [3];
  logic        if_rvalid [3];
  logic [31:0] if_rdata [3];
  logic        d_req [3];
  logic        d_we [3];
  logic [31:0] d_addr [3];
  logic [3:0]  d_be [3];
  logic [31:0] d_wdata [3];
  logic        d_gnt [3];
  logic        d_rvalid [3];
  logic [31:0] d_rdata [3];
  logic        stall_if [3];
  logic        mem_en [3];
  logic        mem_we [3];
  logic [3:0]  mem_be [3];
  logic [5:0]  mem_addr [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall [3];
  logic [31:0] perf_d_grants [3];
`endif

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = k + 1;
    logic [5:0] pipe [L];

    unified_mem_arbiter #(.ADDR_W(6), .MEM_LAT(L), .STARVE_MAX(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req[k]), .if_addr(if_addr[k]), .if_gnt(if_gnt[k]),
      .if_rvalid(if_rvalid[k]), .if_rdata(if_rdata[k]),
      .d_req(d_req[k]), .d_we(d_we[k]), .d_addr(d_addr[k]), .d_be(d_be[k]),
      .d_wdata(d_wdata[k]), .d_gnt(d_gnt[k]), .d_rvalid(d_rvalid[k]), .d_rdata(d_rdata[k]),
      .stall_if(stall_if[k]), .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_be(mem_be[k]),
      .mem_addr(mem_addr[k]), .mem_wdata(mem_wdata[k]),
`ifdef ARB_PERF_CNT_EN
      .mem_rdata(mem_rdata[k]),
      .perf_if_stall(perf_if_stall[k]),
      .perf_d_grants(perf_d_grants[k])
`else
      .mem_rdata(mem_rdata[k])
`endif
    );

    // Memory model: word at address a reads as 0xA5000000 + a, L cycles after the command.
    always @(posedge clk) begin
      pipe[0] <= mem_addr[k];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[k] = {24'hA50000, 2'b00, pipe[L-1]};
  end

  int act = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        m_if_gnt, m_if_rvalid, m_d_gnt, m_d_rvalid, m_stall_if, m_mem_en, m_mem_we;
  logic [31:0] m_if_rdata, m_d_rdata, m_mem_wdata;
  logic [3:0]  m_mem_be;
  logic [5:0]  m_mem_addr;
  assign m_if_gnt    = if_gnt[act];
  assign m_if_rvalid = if_rvalid[act];
  assign m_if_rdata  = if_rdata[act];
  assign m_d_gnt     = d_gnt[act];
  assign m_d_rvalid  = d_rvalid[act];
  assign m_d_rdata   = d_rdata[act];
  assign m_stall_if  = stall_if[act];
  assign m_mem_en    = mem_en[act];
  assign m_mem_we    = mem_we[act];
  assign m_mem_be    = mem_be[act];
  assign m_mem_addr  = mem_addr[act];
  assign m_mem_wdata = mem_wdata[act];

  typedef struct packed {
    int          cyc;
    logic        en;
    logic        gi;
    logic        d;
    logic        we;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } iss_t;

  typedef struct packed {
    int          cyc;
    logic        iv;
    logic        d;
    logic [31:0] data;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic push_iss(input int c, input logic d, input logic we, input logic [3:0] be,
                          input logic [5:0] a, input logic [31:0] wd);
    iss_t e;
    e.cyc = c; e.en = 1'b1; e.gi = !d; e.d = d; e.we = we; e.be = be; e.addr = a; e.wdata = wd;
    iss_q.push_back(e);
  endtask

  task automatic push_rsp(input int c, input logic d, input logic [31:0] data);
    rsp_t e;
    e.cyc = c; e.iv = !d; e.d = d; e.data = data;
    rsp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp_v, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{m_if_gnt, m_if_rvalid, m_if_rdata, m_d_gnt, m_d_rvalid, m_d_rdata, m_stall_if,
             m_mem_en, m_mem_we, m_mem_be, m_mem_addr, m_mem_wdata};
  endfunction

  // Monitor: compares every command and every response against the scoreboard queues.
  always @(negedge clk) begin
    iss_t ai, ei;
    rsp_t ar, er;
    if (m_mem_en || m_if_gnt || m_d_gnt) begin
      ai.cyc = cyc; ai.en = m_mem_en; ai.gi = m_if_gnt; ai.d = m_d_gnt; ai.we = m_mem_we;
      ai.be = m_mem_be; ai.addr = m_mem_addr;
      ai.wdata = (m_d_gnt && m_mem_we) ? m_mem_wdata : 32'h0;
      vectors++;
      if (iss_q.size() == 0) begin
        miscompares++;
        $display("FAIL issue: unexpected command %h at cycle %0d", ai, cyc);
      end else begin
        ei = iss_q.pop_front();
        if (ai !== ei) begin
          miscompares++;
          $display("FAIL issue: got %h expected %h", ai, ei);
        end
      end
    end
    if (m_if_rvalid || m_d_rvalid) begin
      ar.cyc = cyc; ar.iv = m_if_rvalid; ar.d = m_d_rvalid;
      ar.data = m_d_rvalid ? m_d_rdata : m_if_rdata;
      vectors++;
      if (rsp_q.size() == 0) begin
        miscompares++;
        $display("FAIL response: unexpected response %h at cycle %0d", ar, cyc);
      end else begin
        er = rsp_q.pop_front();
        if (ar !== er) begin
          miscompares++;
          $display("FAIL response: got %h expected %h", ar, er);
        end
      end
    end else begin
      vectors++;
      if ((m_if_rdata !== 32'h0) || (m_d_rdata !== 32'h0)) begin
        miscompares++;
        $display("FAIL idle_rdata: got if=%h d=%h expected 0 at cycle %0d", m_if_rdata, m_d_rdata, cyc);
      end
    end
  end

  int t;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if_req[k] = 1'b0; if_addr[k] = 32'h0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = 32'h0; d_be[k] = 4'h0; d_wdata[k] = 32'h0;
    end
    // Reset with both requests pending: everything stays quiet.
    act = 0;
    if_req[0] = 1'b1; d_req[0] = 1'b1;
    step();
    chk("reset_outputs_0", {31'h0, any_out()}, 32'h0);
    step();
    chk("reset_outputs_1", {31'h0, any_out()}, 32'h0);
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    rst_n = 1'b1;
    step();

    // Collision, MEM_LAT=1.
    t = cyc;
    if_req[0] = 1'b1; if_addr[0] = 32'h20;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h10; d_be[0] = 4'b0101;
    push_iss(t, 1'b1, 1'b0, 4'hF, 6'd4, 32'h0);
    push_iss(t + 1, 1'b0, 1'b0, 4'hF, 6'd8, 32'h0);
    push_rsp(t + 1, 1'b1, 32'hA500_0004);
    push_rsp(t + 2, 1'b0, 32'hA500_0008);
    #1 chk("collision_stall_T", {31'h0, m_stall_if}, 32'h1);
    step();
    d_req[0] = 1'b0;
    #1 chk("collision_stall_T1", {31'h0, m_stall_if}, 32'h0);
    step();
    if_req[0] = 1'b0;
    step();
    step();
`ifdef ARB_PERF_CNT_EN
    chk("perf_if_stall", perf_if_stall[0], 32'h1);
    chk("perf_d_grants", perf_d_grants[0], 32'h1);
`endif

    // Store completion, then a load whose offset and high address bits must be dropped.
    t = cyc;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_be[0] = 4'b0011; d_addr[0] = 32'h0C; d_wdata[0] = 32'hDEAD_BEEF;
    push_iss(t, 1'b1, 1'b1, 4'b0011, 6'd3, 32'hDEAD_BEEF);
    push_rsp(t + 1, 1'b1, 32'h0);
    step();
    t = cyc;
    d_we[0] = 1'b0; d_be[0] = 4'h0; d_addr[0] = 32'h1234_5107;
    push_iss(t, 1'b1, 1'b0, 4'hF, 6'd1, 32'h0);
    push_rsp(t + 1, 1'b1, 32'hA500_0001);
    step();
    d_req[0] = 1'b0;
    step();
    step();

    // Starvation: both held, fetch wins after four consecutive data grants.
    t = cyc;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h14;
    if_req[0] = 1'b1; if_addr[0] = 32'hFFFF_FF18;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) begin
        push_iss(t + i, 1'b0, 1'b0, 4'hF, 6'd6, 32'h0);
        push_rsp(t + i + 1, 1'b0, 32'hA500_0006);
      end else begin
        push_iss(t + i, 1'b1, 1'b0, 4'hF, 6'd5, 32'h0);
        push_rsp(t + i + 1, 1'b1, 32'hA500_0005);
      end
    end
    for (int i = 0; i < 10; i++) step();
    d_req[0] = 1'b0; if_req[0] = 1'b0;
    step();
    step();

    // Reset mid-access, MEM_LAT=2: in-flight fetch is dropped, a fresh one proceeds.
    act = 1;
    step();
    t = cyc;
    if_req[1] = 1'b1; if_addr[1] = 32'h08;
    push_iss(t, 1'b0, 1'b0, 4'hF, 6'd2, 32'h0);
    step();
    rst_n = 1'b0;
    #1 chk("midreset_outputs_0", {31'h0, any_out()}, 32'h0);
    step();
    chk("midreset_outputs_1", {31'h0, any_out()}, 32'h0);
    step();
    rst_n = 1'b1;
    push_iss(t + 3, 1'b0, 1'b0, 4'hF, 6'd2, 32'h0);
    push_rsp(t + 5, 1'b0, 32'hA500_0002);
    step();
    if_req[1] = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Back-to-back fetches, MEM_LAT=3.
    act = 2;
    step();
    t = cyc;
    if_req[2] = 1'b1; if_addr[2] = 32'h04;
    for (int i = 0; i < 3; i++) begin
      push_iss(t + 3 * i, 1'b0, 1'b0, 4'hF, 6'd1, 32'h0);
      push_rsp(t + 3 * i + 3, 1'b0, 32'hA500_0001);
    end
    for (int i = 0; i < 7; i++) step();
    if_req[2] = 1'b0;
    for (int i = 0; i < 5; i++) step();

    chk("issue_queue_drained", iss_q.size(), 32'h0);
    chk("response_queue_drained", rsp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Sequences the single shared instruction/data memory of the pipelined RV32 core.
- Arbitrates between two requesters: the IF-stage fetch port (read-only) and the MEM-stage load/store port.
- Issues one memory command at a time and returns each response to its owner after a fixed latency.
- Provides an anti-starvation rule so fetch always makes progress under sustained data traffic.

Parameters:
- ADDR_W, 6, memory word-address width (64 words).
- MEM_LAT, 1, cycles from command issue to read-data valid; legal range 1..4.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; legal range 1..15.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request, held until granted
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_be  in  4  store byte enables
- d_wdata  in  32  store data
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  load data valid, or store completion
- d_rdata  out  32  load data
- stall_if  out  1  if_req && !if_gnt
- mem_en  out  1  memory command strobe
- mem_we  out  1  memory write
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after command

Behaviour:
- Reset:
  - Synchronous on rst_n=0; clears FSM to IDLE, latency counter, starve counter and owner.
  - All outputs 0, including when a request is pending.
  - Reset during BUSY drops the in-flight access: no rvalid is emitted for it.
- FSM states: IDLE, BUSY.
  - Issue is legal in IDLE, and in the final BUSY cycle (the response cycle).
  - Issuing enters or stays in BUSY with cnt=0.
  - With no request at the response cycle, the FSM returns to IDLE.
- Issue:
  - Combinational in the issue cycle T: one gnt, mem_en=1, and mem_* driven from the winner.
  - Fetch issue drives mem_we=0 and mem_be=4'hF.
  - Data issue drives mem_we=d_we and mem_be=d_we ? d_be : 4'hF.
  - No grant and mem_en=0 outside issue-legal cycles.
- Response:
  - Owner rvalid asserts for exactly one cycle at T+MEM_LAT.
  - Loads and fetches return rdata = mem_rdata in that cycle.
  - Stores return d_rvalid=1 with d_rdata=0.
  - rdata is 0 when rvalid is 0.
  - Throughput is one access per MEM_LAT cycles.
- Priority:
  - Data wins over fetch by default.
  - starve_cnt increments on each data grant made while if_req=1.
  - starve_cnt clears on a fetch grant or whenever if_req=0.
  - When starve_cnt==STARVE_MAX and both requests are present, fetch wins.
  - starve_cnt saturates at STARVE_MAX.
- Requesters must hold req and payload stable until their gnt; the arbiter latches only the owner, not the payload.
- stall_if is purely combinational.
- Address bits [1:0] and bits above ADDR_W+1 are ignored.

Optional Feature:
- Macro: ARB_PERF_CNT_EN
- When defined:
  - Adds output perf_if_stall[31:0], counting cycles with stall_if=1.
  - Adds output perf_d_grants[31:0], counting d_gnt pulses.
  - Both counters wrap at 2^32 and clear on reset.
- When undefined: both ports and both counters are absent, and there is no other behavioural change.

Test Plan:
- Reset mid-access:
  - Stimulus: MEM_LAT=2; if_req at 0x08; assert rst_n=0 at T+1.
  - Required: if_rvalid never asserts; all outputs 0 during reset; after release, a fresh fetch at 0x08 gets mem_addr=2.
- Collision:
  - Stimulus: MEM_LAT=1; if_req and d_req (load at 0x10) in the same cycle.
  - Required: d_gnt at T with mem_addr=4, d_rvalid at T+1; if_gnt at T+1 with stall_if=1 during T; if_rvalid at T+2.
- Store completion:
  - Stimulus: d_we=1, d_be=4'b0011, d_addr=0x0C, d_wdata=0xDEADBEEF.
  - Required: mem_we=1, mem_be=4'b0011, mem_addr=3, mem_wdata=0xDEADBEEF; d_rvalid=1 with d_rdata=0 after MEM_LAT cycles.
- Starvation:
  - Stimulus: STARVE_MAX=4; d_req and if_req both held continuously.
  - Required: grant sequence D,D,D,D,I,D,D,D,D,I...
- Back-to-back latency:
  - Stimulus: MEM_LAT=3; continuous if_req.
  - Required: if_gnt on cycles 0,3,6; if_rvalid on cycles 3,6,9; mem_en never asserted in intermediate cycles.
- Perf counters:
  - Stimulus: build with ARB_PERF_CNT_EN; run the collision scenario.
  - Required: perf_if_stall=1 and perf_d_grants=1.
